// File: rtl/async_fifo_core.sv
// Single-clock FIFO with a registered read port and full/empty/almost status flags.
// Optional sticky overflow/underflow outputs are built when FIFO_ERR_FLAGS_EN is defined.
module async_fifo_core #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int SIZE  = $clog2(DEPTH),
    parameter int DIFF  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic             overflow,
    output logic             underflow
`endif
);

    // Handshake: a write is taken on a rising edge when wr_en=1 and full=0 (full acts as
    // not-ready); a read is taken when rd_en=1 and empty=0, and rd_data is valid after that edge.
    // Requests made while not ready are dropped without side effects on data or pointers.

    localparam logic [SIZE:0] AF_LEVEL = (SIZE+1)'(DEPTH - DIFF);
    localparam logic [SIZE:0] AE_LEVEL = (SIZE+1)'(DIFF);
    localparam logic [SIZE:0] PTR_ONE  = (SIZE+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [SIZE:0]    wr_ptr_q, wr_ptr_d;
    logic [SIZE:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic [SIZE:0]    count;
    logic             wr_accept;
    logic             rd_accept;

    // Flags come only from the registered pointers, so they never see this cycle's requests.
    assign count        = wr_ptr_q - rd_ptr_q;
    assign empty        = (wr_ptr_q == rd_ptr_q);
    assign full         = (wr_ptr_q[SIZE] != rd_ptr_q[SIZE]) &&
                          (wr_ptr_q[SIZE-1:0] == rd_ptr_q[SIZE-1:0]);
    assign almost_full  = !full && (count >= AF_LEVEL);
    assign almost_empty = !empty && (count <= AE_LEVEL);

    assign wr_accept = wr_en && !full;
    assign rd_accept = rd_en && !empty;
    assign rd_data   = rd_data_q;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rd_data_d = rd_data_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_accept) begin
            rd_ptr_d  = rd_ptr_q + PTR_ONE;
            rd_data_d = mem_q[rd_ptr_q[SIZE-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Storage is deliberately not cleared by reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (!rst && wr_accept) begin
            mem_q[wr_ptr_q[SIZE-1:0]] <= wr_data;
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_q  | (wr_en && full);
            underflow_q <= underflow_q | (rd_en && empty);
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_async_fifo_core.sv
// Randomized bench for async_fifo_core against a queue-based reference model.
// Optional error-flag checks are enabled when FIFO_ERR_FLAGS_EN is defined.
module tb_async_fifo_core;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int DIFF  = 2;

    logic             clk;
    logic             rst;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
`ifdef FIFO_ERR_FLAGS_EN
    logic             overflow;
    logic             underflow;
`endif

    async_fifo_core #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DIFF(DIFF)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .overflow     (overflow),
        .underflow    (underflow)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] exp_rd;
    bit               exp_ovf;
    bit               exp_unf;
    int               n_checks = 0;
    int               n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_all();
        int sz;
        sz = exp_q.size();
        check_eq("rd_data",      32'(rd_data),      32'(exp_rd));
        check_eq("empty",        32'(empty),        32'(sz == 0));
        check_eq("full",         32'(full),         32'(sz == DEPTH));
        check_eq("almost_full",  32'(almost_full),  32'(sz < DEPTH && sz >= DEPTH - DIFF));
        check_eq("almost_empty", 32'(almost_empty), 32'(sz > 0 && sz <= DIFF));
`ifdef FIFO_ERR_FLAGS_EN
        check_eq("overflow",     32'(overflow),     32'(exp_ovf));
        check_eq("underflow",    32'(underflow),    32'(exp_unf));
`endif
    endtask

    // ---------------- driver ----------------
    // Inputs change 1 time unit after a rising edge; the model advances on the edge.
    task automatic step(input bit r, input bit w, input logic [WIDTH-1:0] d, input bit rd);
        bit was_full;
        bit was_empty;
        rst     = r;
        wr_en   = w;
        wr_data = d;
        rd_en   = rd;
        @(posedge clk);
        was_full  = (exp_q.size() == DEPTH);
        was_empty = (exp_q.size() == 0);
        if (r) begin
            exp_q.delete();
            exp_rd  = '0;
            exp_ovf = 1'b0;
            exp_unf = 1'b0;
        end else begin
            if (w && was_full)  exp_ovf = 1'b1;
            if (rd && was_empty) exp_unf = 1'b1;
            if (rd && !was_empty) exp_rd = exp_q.pop_front();
            if (w && !was_full)  exp_q.push_back(d);
        end
        #1;
        check_all();
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, '0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic write_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, WIDTH'($urandom_range(0, 255)), 1'b0);
    endtask

    task automatic read_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        exp_rd = '0; exp_ovf = 1'b0; exp_unf = 1'b0;

        // Reset state
        do_reset();
        check_eq("reset_empty",   32'(empty),   32'd1);
        check_eq("reset_rd_data", 32'(rd_data), 32'd0);

        // Sanity: 23 then 56
        step(1'b0, 1'b1, 8'd23, 1'b0);
        check_eq("sanity_ae1", 32'(almost_empty), 32'd1);
        step(1'b0, 1'b1, 8'd56, 1'b0);
        check_eq("sanity_ae2", 32'(almost_empty), 32'd1);
        step(1'b0, 1'b0, '0, 1'b1);
        check_eq("sanity_rd0", 32'(rd_data), 32'd23);
        step(1'b0, 1'b0, '0, 1'b1);
        check_eq("sanity_rd1", 32'(rd_data), 32'd56);
        check_eq("sanity_empty", 32'(empty), 32'd1);

        // Fill, drain, refill across the pointer wrap
        do_reset();
        write_n(16);
        check_eq("fill_full", 32'(full), 32'd1);
        read_n(16);
        write_n(16);
        check_eq("wrap_full", 32'(full), 32'd1);
        read_n(16);

        // Half: fill, read 8, write 8, drain
        do_reset();
        write_n(16);
        read_n(8);
        write_n(8);
        check_eq("half_full", 32'(full), 32'd1);
        read_n(16);

        // Overflow: two dropped writes
        do_reset();
        write_n(18);
        check_eq("ovf_full", 32'(full), 32'd1);
        read_n(16);

        // Underflow: two ignored reads
        do_reset();
        write_n(16);
        read_n(18);
        check_eq("unf_empty", 32'(empty), 32'd1);

        // Simultaneous at count 14, plus simultaneous at full and empty
        do_reset();
        write_n(14);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, WIDTH'($urandom_range(0, 255)), 1'b1);
        check_eq("simul_af", 32'(almost_full), 32'd1);
        write_n(2);
        step(1'b0, 1'b1, 8'hA5, 1'b1);
        read_n(16);
        step(1'b0, 1'b1, 8'h5A, 1'b1);
        read_n(1);
        check_eq("simul_empty_wr", 32'(rd_data), 32'h5A);

        // Reset in mid-fill
        write_n(5);
        step(1'b1, 1'b1, 8'hFF, 1'b1);
        rst = 1'b0;
        check_eq("midrst_empty",   32'(empty),   32'd1);
        check_eq("midrst_rd_data", 32'(rd_data), 32'd0);

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            int mode;
            bit w;
            bit r;
            mode = (i / 300) % 3;
            w = ($urandom_range(0, 9) < (mode == 0 ? 7 : (mode == 1 ? 3 : 5)));
            r = ($urandom_range(0, 9) < (mode == 0 ? 3 : (mode == 1 ? 7 : 5)));
            step($urandom_range(0, 299) == 0, w, WIDTH'($urandom_range(0, 255)), r);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
